// File: rtl/quad2steer.sv
// Quadrature steering-wheel decoder: synchronise, prescale, debounce and Gray-decode
// an A/B encoder into a wrapping position, step pulses, held direction flags and an error count.
module quad2steer #(
    parameter int FILT_LEN   = 3,
    parameter int HOLD_TICKS = 8
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [15:0] clkdiv,
    input  logic        quad_a,
    input  logic        quad_b,
    output logic [7:0]  position,
    output logic        step_cw,
    output logic        step_ccw,
    output logic        right,
    output logic        left,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] FILT_W = 4'(FILT_LEN);
    localparam logic [7:0] HOLD_W = 8'(HOLD_TICKS);

    typedef enum logic [1:0] {MV_NONE, MV_CW, MV_CCW, MV_JUMP} move_t;
    typedef enum logic [1:0] {IDLE, RIGHT, LEFT} dir_t;

    logic [1:0]  meta_ab, sync_ab;
    logic [15:0] pre_cnt, pre_limit;
    logic        tick;
    logic [1:0]  cand;
    logic [3:0]  stable_cnt;
    logic        accept;
    logic [1:0]  acc_ab;
    logic        initd;
    move_t       move;
    dir_t        state, state_nxt;
    logic [7:0]  hold_cnt, hold_nxt;

    // NOTE: every clocked process uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            meta_ab <= '0;
            sync_ab <= '0;
        end else begin
            meta_ab <= {quad_a, quad_b};
            sync_ab <= meta_ab;
        end
    end

    // Compare against the live clkdiv so a smaller divider wraps immediately.
    always_comb begin
        pre_limit = (clkdiv <= 16'd1) ? 16'd0 : clkdiv - 16'd1;
        tick      = (pre_cnt >= pre_limit);
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) pre_cnt <= '0;
        else          pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
    end

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        accept = 1'b0;
        if (tick) begin
            if (sync_ab == cand) accept = (stable_cnt == FILT_W - 4'd1);
            else                 accept = (FILT_W == 4'd1);
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cand       <= '0;
            stable_cnt <= '0;
            acc_ab     <= '0;
            initd      <= 1'b0;
        end else begin
            if (tick) begin
                if (sync_ab == cand) begin
                    if (stable_cnt != 4'hF) stable_cnt <= stable_cnt + 4'd1;
                end else begin
                    cand       <= sync_ab;
                    stable_cnt <= 4'd1;
                end
            end
            if (accept) begin
                acc_ab <= sync_ab;
                initd  <= 1'b1;
            end
        end
    end

    // Gray sequence 00->10->11->01->00 is clockwise; the first acceptance only seeds acc_ab.
    always_comb begin
        move = MV_NONE;
        if (accept && initd) begin
            case ({acc_ab, sync_ab})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: move = MV_CW;
                4'b1000, 4'b1110, 4'b0111, 4'b0001: move = MV_CCW;
                4'b0011, 4'b1100, 4'b1001, 4'b0110: move = MV_JUMP;
                default:                            move = MV_NONE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            position <= '0;
            err_cnt  <= '0;
            step_cw  <= 1'b0;
            step_ccw <= 1'b0;
            err      <= 1'b0;
        end else begin
            step_cw  <= (move == MV_CW);
            step_ccw <= (move == MV_CCW);
            err      <= (move == MV_JUMP);
            if (move == MV_CW)  position <= position + 8'd1;
            if (move == MV_CCW) position <= position - 8'd1;
            if (move == MV_JUMP && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    // A step always lands on a tick; it reloads the hold instead of decrementing it.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        if (move == MV_CW) begin
            state_nxt = RIGHT;
            hold_nxt  = HOLD_W;
        end else if (move == MV_CCW) begin
            state_nxt = LEFT;
            hold_nxt  = HOLD_W;
        end else if (tick && state != IDLE) begin
            if (hold_cnt <= 8'd1) begin
                state_nxt = IDLE;
                hold_nxt  = '0;
            end else begin
                hold_nxt  = hold_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            right    <= 1'b0;
            left     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            right    <= (state_nxt == RIGHT);
            left     <= (state_nxt == LEFT);
        end
    end

endmodule

// File: doc/quad2steer.md
QUAD2STEER -- requirements
Module: quad2steer

Interface
REQ-001 FILT_LEN, 3: consecutive sample ticks an {A,B} value must be stable before it is accepted (range 1..15).
REQ-002 HOLD_TICKS, 8: sample ticks a left/right output is held after the last step (range 1..255).
REQ-003 CLK  in  1  system clock; all logic is on the rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 clkdiv  in  16  sample-tick divider; 0 or 1 produces a tick every CLK.
REQ-006 quad_a  in  1  encoder phase A, asynchronous to CLK (steering A).
REQ-007 quad_b  in  1  encoder phase B, asynchronous to CLK (steering B).
REQ-008 position  out  8  unsigned step count, wrap-around.
REQ-009 step_cw  out  1  one-CLK pulse per accepted clockwise step.
REQ-010 step_ccw  out  1  one-CLK pulse per accepted counter-clockwise step.
REQ-011 right  out  1  held while the wheel is turning clockwise.
REQ-012 left  out  1  held while the wheel is turning counter-clockwise.
REQ-013 err  out  1  one-CLK pulse on an illegal double transition.
REQ-014 err_cnt  out  8  illegal-transition count; saturates at 255.

Function
REQ-015 quad_a and quad_b shall each pass through a 2-flop synchronizer before any other use.
REQ-016 Prescaler: a 16-bit counter shall count 0..clkdiv-1 and assert tick for 1 CLK when it wraps.
REQ-017 A clkdiv change shall take effect no later than the next wrap.
REQ-018 Filter: on each tick, if synced {A,B} equals the candidate, the stable count increments (saturating); otherwise the candidate is loaded and the count is set to 1.
REQ-019 The candidate shall become the accepted value on the tick where the stable count reaches FILT_LEN.
REQ-020 Gray decode, {A,B}:
  - Clockwise (+1) = 00->10->11->01->00.
  - Counter-clockwise (-1) = the reverse sequence.
  - New value equal to the old value: no action.
REQ-021 Double jump (00<->11, 10<->01):
  - err pulses.
  - err_cnt increments, saturating at 255.
  - position is unchanged.
  - The accepted value is still updated.
REQ-022 First acceptance after reset shall only initialise the accepted value, with no step and no err; an init flag tracks this.
REQ-023 position shall be updated (+1 or -1, modulo 256) on the CLK after acceptance; 255+1=0 and 0-1=255.
REQ-024 step_cw / step_ccw / err shall be registered, asserted in the same cycle as the position update, and mutually exclusive.
REQ-025 Direction FSM states: IDLE, RIGHT, LEFT.
  - A CW step from any state -> RIGHT, with the hold counter loaded to HOLD_TICKS.
  - A CCW step from any state -> LEFT, with the hold counter loaded to HOLD_TICKS.
  - In RIGHT/LEFT, each tick without a step decrements the hold counter; reaching 0 -> IDLE.
REQ-026 right=1 only in RIGHT; left=1 only in LEFT; both outputs are registered from the state.
REQ-027 A step in the opposite direction shall switch states on the same cycle as the step pulse, with no IDLE cycle between.
REQ-028 A step and a tick in the same cycle: the step wins (counter reloaded, no decrement).
REQ-029 An err event shall not change the direction FSM or the hold counter.

Reset
REQ-030 Reset_n=0 shall asynchronously clear all of the following:
  - position=0, err_cnt=0.
  - step_cw=step_ccw=err=0, left=right=0.
  - FSM=IDLE.
  - Prescaler, stable count and hold counter = 0.
  - Synchronizer flops = 0.
  - init flag = 0 (not initialised).
REQ-031 Reset asserted mid-step or mid-hold shall discard the pending transition.
REQ-032 After release, the next accepted value shall follow REQ-022.

Verification
REQ-033 clkdiv=1, FILT_LEN=3, A/B held 00 from reset, then 4 full CW cycles (16 edges) spaced 10 CLK -> position=16, 16 step_cw pulses, right=1, err_cnt=0.
REQ-034 After REQ-033, inputs idle -> right falls exactly 8 ticks after the last step_cw; FSM=IDLE.
REQ-035 position=0, one CCW edge 00->01 -> position=255, step_ccw pulse, left=1.
REQ-036 Accepted 00, apply 11 stable -> err pulse, err_cnt=1, position unchanged; 300 such jumps -> err_cnt=255.
REQ-037 A 1-tick glitch 00->10->00 with FILT_LEN=3 -> no step and no position change; a 2-tick glitch is also rejected.
REQ-038 Reset_n pulsed low while in RIGHT with inputs at 11 -> all outputs 0; after release, the first accepted 11 produces no step and no err.
